// File: rtl/pipelined_binary_adder.sv
// pipelined_binary_adder: WIDTH-bit adder with the carry chain split into STAGES
// register-separated chunks. Valid/ready handshake on both sides; a stalled
// output freezes the whole pipe.
// Optional macro OVF_FLAG_EN adds a registered signed-overflow output.
module pipelined_binary_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             C_out
`ifdef OVF_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CH   = WIDTH / STAGES;
  localparam int unsigned CHP  = CH + 1;
  localparam int unsigned LAST = STAGES - 1;

  // Reject configurations that cannot be split into equal chunks
  if ((WIDTH < 1) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_check
    $error("pipelined_binary_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // Stage registers. Operands shift down by one chunk per stage so the chunk
  // being added always sits in the low CH bits; finished sum chunks shift in
  // from the top so chunk 0 lands at bit 0 after the last stage.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];

  // Stage inputs and next values
  logic             feed_v [STAGES];
  logic [WIDTH-1:0] feed_a [STAGES];
  logic [WIDTH-1:0] feed_b [STAGES];
  logic [WIDTH-1:0] feed_s [STAGES];
  logic             feed_c [STAGES];
  logic [CH:0]      chunk  [STAGES];
  logic [WIDTH-1:0] nxt_a  [STAGES];
  logic [WIDTH-1:0] nxt_b  [STAGES];
  logic [WIDTH-1:0] nxt_s  [STAGES];

  logic stall;
  logic accept;

  // Handshake: any held result with no taker freezes every stage
  assign stall    = v_q[LAST] & ~out_ready;
  assign in_ready = rst | ~stall;
  assign accept   = in_valid & in_ready;

  // Route each stage's input: ports for stage 0, previous register otherwise
  always_comb begin
    feed_v[0] = accept;
    feed_a[0] = A;
    feed_b[0] = B;
    feed_s[0] = '0;
    feed_c[0] = C_in;
    for (int k = 1; k < STAGES; k++) begin
      feed_v[k] = v_q[k-1];
      feed_a[k] = a_q[k-1];
      feed_b[k] = b_q[k-1];
      feed_s[k] = s_q[k-1];
      feed_c[k] = c_q[k-1];
    end
  end

  // Per-stage chunk add and shift of operands / finished sum bits
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = CHP'(feed_a[k][CH-1:0]) + CHP'(feed_b[k][CH-1:0]) + CHP'(feed_c[k]);
      nxt_a[k] = feed_a[k] >> CH;
      nxt_b[k] = feed_b[k] >> CH;
      nxt_s[k] = (feed_s[k] >> CH) | (WIDTH'(chunk[k][CH-1:0]) << (WIDTH - CH));
    end
  end

  // Pipeline advance: reset clears everything, stall holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= feed_v[k];
        a_q[k] <= nxt_a[k];
        b_q[k] <= nxt_b[k];
        s_q[k] <= nxt_s[k];
        c_q[k] <= chunk[k][CH];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign C_out     = c_q[LAST];

`ifdef OVF_FLAG_EN
  logic ovf_q;
  logic ovf_d;

  // Signed overflow from the operand MSBs, which reach the last stage in its top chunk
  always_comb begin
    ovf_d = (feed_a[LAST][CH-1] == feed_b[LAST][CH-1]) &
            (chunk[LAST][CH-1] != feed_a[LAST][CH-1]);
  end

  // Overflow flag registered alongside the final sum chunk
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_binary_adder.sv
// Bench for pipelined_binary_adder: WIDTH=16/STAGES=4 main instance plus a
// WIDTH=4/STAGES=1 instance. Reference is a delay line of exact sums.
module tb_pipelined_binary_adder;

  localparam int unsigned W  = 16;
  localparam int unsigned S  = 4;
  localparam int unsigned W1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  A, B, sum;
  logic          C_in, C_out;

  logic          v1, rdy1, ov1, ordy1;
  logic [W1-1:0] a1, b1, s1;
  logic          c1, co1;

`ifdef OVF_FLAG_EN
  logic overflow, ovf1;
`endif

  pipelined_binary_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C_in(C_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .C_out(C_out)
`ifdef OVF_FLAG_EN
    , .overflow(overflow)
`endif
  );

  pipelined_binary_adder #(.WIDTH(W1), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .A(a1), .B(b1), .C_in(c1), .out_valid(ov1), .out_ready(ordy1),
    .sum(s1), .C_out(co1)
`ifdef OVF_FLAG_EN
    , .overflow(ovf1)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference: S-deep delay line of {valid, exact sum, signed overflow}
  logic         m_v [S];
  logic [W:0]   m_d [S];
  logic         m_o [S];

  function automatic logic ovf_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic exp_ready();
    return rst | ~(m_v[S-1] & ~out_ready);
  endfunction

  // One clock: advance the reference exactly as the handshake rules dictate
  task automatic tick();
    logic stall_m;
    stall_m = m_v[S-1] & ~out_ready;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        m_v[i] = 1'b0; m_d[i] = '0; m_o[i] = 1'b0;
      end
    end else if (!stall_m) begin
      for (int i = S - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; m_o[i] = m_o[i-1];
      end
      m_v[0] = in_valid;
      m_d[0] = (W+1)'(A) + (W+1)'(B) + (W+1)'(C_in);
      m_o[0] = ovf_of(A, B, C_in);
    end
    #1;
  endtask

  task automatic randomize_ops();
    A    = W'($urandom);
    B    = W'($urandom);
    C_in = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; C_in = 1'b0;
    v1 = 1'b0; ordy1 = 1'b1; a1 = '0; b1 = '0; c1 = 1'b0;
    for (int i = 0; i < S; i++) begin
      m_v[i] = 1'b0; m_d[i] = '0; m_o[i] = 1'b0;
    end
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    n_cmp++; if (C_out !== 1'b0) begin n_err++; $display("FAIL reset_c_out got=%b exp=0", C_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_s1_out_valid got=%b exp=0", ov1); end
`ifdef OVF_FLAG_EN
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`endif
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_carry_chain();
    A = 16'hFFFF; B = 16'h0001; C_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= int'(S); i++) begin
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== (i == int'(S))) begin
        n_err++; $display("FAIL carry_latency edge=%0d got=%b exp=%b", i, out_valid, (i == int'(S)));
      end
    end
    n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL carry_sum got=%h exp=0000", sum); end
    n_cmp++; if (C_out !== 1'b1) begin n_err++; $display("FAIL carry_c_out got=%b exp=1", C_out); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL carry_bubble got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    int seen, first, last;
    seen = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 8);
      randomize_ops();
      tick();
      n_cmp++;
      if (out_valid !== m_v[S-1]) begin
        n_err++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, out_valid, m_v[S-1]);
      end
      if (m_v[S-1]) begin
        n_cmp++;
        if ({C_out, sum} !== m_d[S-1]) begin
          n_err++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", c, {C_out, sum}, m_d[S-1]);
        end
      end
      if (out_valid === 1'b1) begin
        seen++;
        if (first < 0) first = c;
        last = c;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (seen != 8) begin n_err++; $display("FAIL stream_count got=%0d exp=8", seen); end
    n_cmp++; if (last - first != 7) begin n_err++; $display("FAIL stream_contiguous got_span=%0d exp=7", last - first); end
  endtask

  task automatic test_back_pressure();
    int accepted, delivered;
    accepted = 0; delivered = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid  = (accepted < 6);
      out_ready = !(c >= 5 && c <= 7);
      randomize_ops();
      #1;
      n_cmp++;
      if (in_ready !== exp_ready()) begin
        n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_ready());
      end
      if (in_valid && exp_ready()) accepted++;
      if (out_valid === 1'b1 && out_ready) delivered++;
      tick();
      n_cmp++;
      if (out_valid !== m_v[S-1]) begin
        n_err++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", c, out_valid, m_v[S-1]);
      end
      if (m_v[S-1]) begin
        n_cmp++;
        if ({C_out, sum} !== m_d[S-1]) begin
          n_err++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, {C_out, sum}, m_d[S-1]);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (delivered != 6) begin n_err++; $display("FAIL bp_delivered got=%0d exp=6", delivered); end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      randomize_ops();
      tick();
    end
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    randomize_ops();
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_err++; $display("FAIL rstmid_sum got=%h exp=0000", sum); end
    n_cmp++; if (C_out !== 1'b0) begin n_err++; $display("FAIL rstmid_c_out got=%b exp=0", C_out); end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=0", c, out_valid); end
    end
    in_valid = 1'b1;
    randomize_ops();
    for (int c = 0; c < 6; c++) begin
      tick();
      in_valid = 1'b0;
      if (out_valid === 1'b1) seen++;
      n_cmp++;
      if (out_valid !== m_v[S-1]) begin
        n_err++; $display("FAIL rstmid_valid cyc=%0d got=%b exp=%b", c, out_valid, m_v[S-1]);
      end
      if (m_v[S-1]) begin
        n_cmp++;
        if ({C_out, sum} !== m_d[S-1]) begin
          n_err++; $display("FAIL rstmid_data cyc=%0d got=%h exp=%h", c, {C_out, sum}, m_d[S-1]);
        end
      end
    end
    n_cmp++; if (seen != 1) begin n_err++; $display("FAIL rstmid_post_count got=%0d exp=1", seen); end
  endtask

`ifdef OVF_FLAG_EN
  task automatic test_overflow();
    int k;
    k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      if (c == 0) begin A = 16'h7FFF; B = 16'h0001; C_in = 1'b0; end
      else if (c == 1) begin A = 16'h8000; B = 16'h8000; C_in = 1'b0; end
      else randomize_ops();
      tick();
      if (m_v[S-1]) begin
        n_cmp++;
        if ({overflow, C_out, sum} !== {m_o[S-1], m_d[S-1]}) begin
          n_err++; $display("FAIL ovf_data cyc=%0d got=%h exp=%h", c, {overflow, C_out, sum}, {m_o[S-1], m_d[S-1]});
        end
      end
      if (out_valid === 1'b1) begin
        if (k == 0) begin
          n_cmp++;
          if ({overflow, C_out, sum} !== {1'b1, 1'b0, 16'h8000}) begin
            n_err++; $display("FAIL ovf_pos got=%h exp=%h", {overflow, C_out, sum}, {1'b1, 1'b0, 16'h8000});
          end
        end else if (k == 1) begin
          n_cmp++;
          if ({overflow, C_out, sum} !== {1'b1, 1'b1, 16'h0000}) begin
            n_err++; $display("FAIL ovf_neg got=%h exp=%h", {overflow, C_out, sum}, {1'b1, 1'b1, 16'h0000});
          end
        end
        k++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (k != 8) begin n_err++; $display("FAIL ovf_count got=%0d exp=8", k); end
  endtask
`endif

  task automatic test_single_stage();
    logic [W1:0] exp;
    in_valid = 1'b0; ordy1 = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          v1 = 1'b1; a1 = W1'(a); b1 = W1'(b); c1 = 1'(c);
          exp = (W1+1)'(a + b + c);
          tick();
          n_cmp++;
          if (ov1 !== 1'b1 || {co1, s1} !== exp) begin
            n_err++; $display("FAIL s1_add a=%0d b=%0d c=%0d got=%b/%h exp=1/%h", a, b, c, ov1, {co1, s1}, exp);
          end
        end
      end
    end
    v1 = 1'b0;
    tick();
    n_cmp++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL s1_bubble got=%b exp=0", ov1); end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_stream();
    test_back_pressure();
    test_reset_mid_op();
`ifdef OVF_FLAG_EN
    test_overflow();
`endif
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
